// File: rtl/spi_master.sv
// SPI mode-0 master: one 8-bit frame per start, with optional SSEL hold between frames.
// Build option: define SPI_MASTER_LSB_FIRST_EN for LSB-first framing (default MSB first).
module spi_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       hold,
  input  logic [7:0] byte_send,
  output logic       busy,
  output logic       byte_done,
  output logic [7:0] byte_data_received,
  output logic       SCK,
  output logic       MOSI,
  input  logic       MISO,
  output logic       SSEL
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {StIdle, StLead, StHigh, StLow, StGap, StHeld} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] phase_q, phase_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      tx_q, tx_d;
  logic [7:0]      rx_q, rx_d;
  logic [7:0]      rxdata_q, rxdata_d;
  logic            hold_q, hold_d;
  logic            mosi_q, mosi_d;
  logic            done_q, done_d;
  logic            sck_q, ssel_q, busy_q;
  logic            phase_last;

  assign phase_last = (phase_q == CntW'(CLK_DIV - 1));

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    bit_d    = bit_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    rxdata_d = rxdata_q;
    hold_d   = hold_q;
    mosi_d   = mosi_q;
    done_d   = 1'b0;
    case (state_q)
      StIdle, StHeld: begin
        if (start) begin
          tx_d    = byte_send;
          hold_d  = hold;
          phase_d = '0;
          bit_d   = '0;
          state_d = StLead;
`ifdef SPI_MASTER_LSB_FIRST_EN
          mosi_d  = byte_send[0];
`else
          mosi_d  = byte_send[7];
`endif
        end
      end
      StLead: begin
        if (phase_last) begin
          phase_d = '0;
          state_d = StHigh;
        end else begin
          phase_d = phase_q + CntW'(1);
        end
      end
      StHigh: begin
        if (phase_last) begin
          phase_d = '0;
          state_d = StLow;
`ifdef SPI_MASTER_LSB_FIRST_EN
          rx_d = {MISO, rx_q[7:1]};
          if (bit_q != 3'd7) begin
            tx_d   = {1'b0, tx_q[7:1]};
            mosi_d = tx_q[1];
          end
`else
          rx_d = {rx_q[6:0], MISO};
          if (bit_q != 3'd7) begin
            tx_d   = {tx_q[6:0], 1'b0};
            mosi_d = tx_q[6];
          end
`endif
        end else begin
          phase_d = phase_q + CntW'(1);
        end
      end
      StLow: begin
        if (phase_last) begin
          phase_d = '0;
          if (bit_q == 3'd7) begin
            done_d   = 1'b1;
            rxdata_d = rx_q;
            state_d  = hold_q ? StHeld : StGap;
          end else begin
            bit_d   = bit_q + 3'd1;
            state_d = StHigh;
          end
        end else begin
          phase_d = phase_q + CntW'(1);
        end
      end
      StGap: begin
        if (phase_last) begin
          phase_d = '0;
          state_d = StIdle;
        end else begin
          phase_d = phase_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Bus outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      phase_q  <= '0;
      bit_q    <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      rxdata_q <= '0;
      hold_q   <= 1'b0;
      mosi_q   <= 1'b0;
      done_q   <= 1'b0;
      sck_q    <= 1'b0;
      ssel_q   <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      rxdata_q <= rxdata_d;
      hold_q   <= hold_d;
      mosi_q   <= mosi_d;
      done_q   <= done_d;
      sck_q    <= (state_d == StHigh);
      ssel_q   <= (state_d == StIdle) || (state_d == StGap);
      busy_q   <= (state_d == StLead) || (state_d == StHigh) || (state_d == StLow) ||
                  (state_d == StGap);
    end
  end

  assign busy               = busy_q;
  assign byte_done          = done_q;
  assign byte_data_received = rxdata_q;
  assign SCK                = sck_q;
  assign MOSI               = mosi_q;
  assign SSEL               = ssel_q;

endmodule
